muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on posedge clk.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-004 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port rs_in  input  32  operand A (dividend / multiplicand), taken from register-file rs_out.
REQ-006 SHALL have port rt_in  input  32  operand B (divisor / multiplier), taken from register-file rt_out.
REQ-007 SHALL have port hi_we  input  1  MTHI: load rs_in into HI.
REQ-008 SHALL have port lo_we  input  1  MTLO: load rs_in into LO.
REQ-009 SHALL have port hi  output  32  HI register, feeds the MFHI write-back path.
REQ-010 SHALL have port lo  output  32  LO register, feeds the MFLO write-back path.
REQ-011 SHALL have port busy  output  1  high while an operation is in flight.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the result is committed.
REQ-013 SHALL have port div_by_zero  output  1  one-cycle pulse alongside done when a DIV/DIVU had rt_in==0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIN; busy = (state != IDLE).
REQ-015 In IDLE with start=1, SHALL latch op, |rs_in|, |rt_in| (two's-complement magnitude for MULT/DIV, raw for MULTU/DIVU) and the result signs, clear a 5-bit counter, and go to CALC.
REQ-016 CALC SHALL perform one iteration per cycle for exactly 32 cycles: shift-add for multiply (64-bit product), restoring shift-subtract for divide; counter 31 -> FIN.
REQ-017 FIN (1 cycle) SHALL apply sign correction, write HI/LO, pulse done, and return to IDLE at the same edge; commit edge = start edge + 33 cycles.
REQ-018 Multiply SHALL write HI = product[63:32] and LO = product[31:0]; MULT product negated when operand signs differ.
REQ-019 Divide SHALL write LO = quotient and HI = remainder; quotient negated when signs differ (DIV), remainder takes the dividend's sign.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000 with no flag.
REQ-021 Divide with rt_in==0 SHALL still take the full 33-cycle latency, leave HI/LO unchanged, and pulse div_by_zero with done.
REQ-022 start while busy SHALL be ignored; the in-flight operation SHALL be unaffected.
REQ-023 hi_we/lo_we in IDLE SHALL load rs_in into HI/LO at the next edge; while busy they SHALL be ignored.
REQ-024 start and hi_we/lo_we asserted together in IDLE: start wins; the MTHI/MTLO write SHALL be dropped.
REQ-025 hi and lo SHALL hold their previous values throughout CALC (no partial results visible).
REQ-026 done and div_by_zero SHALL be registered outputs, never high outside the FIN-exit cycle.

Reset
REQ-027 reset=1 SHALL asynchronously force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_by_zero=0.
REQ-028 reset asserted mid-operation SHALL abort the operation with no HI/LO commit; the next start after reset release SHALL behave normally.

Verification
REQ-029 MULT rs=0xFFFFFFFD (-3), rt=5 -> busy 33 cycles, done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-030 MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 at start edge + 33.
REQ-031 DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); DIVU rs=7, rt=2 -> LO=3, HI=1.
REQ-032 MTHI rs=0x12345678, then DIVU rs=7, rt=0 -> done and div_by_zero pulse together, HI stays 0x12345678.
REQ-033 MULTU 2*3 started, second start (DIVU 9/3) issued 5 cycles later plus lo_we=1 -> second start and lo_we ignored, LO=6, HI=0.
REQ-034 reset pulsed 10 cycles into a MULT -> HI=LO=0, busy=0 immediately, no done; a fresh MULT 4*4 then gives LO=16.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative 32x32 multiply / 32/32 divide unit with HI/LO
//                result registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
//                Fixed 33-cycle latency from start edge to commit edge.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_in,
  input  logic [31:0] rt_in,
  input  logic        hi_we,
  input  logic        lo_we,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_opnd;   // multiplicand (mult) or divisor (div) magnitude
  logic [63:0] r_acc;    // {partial product, multiplier} or {remainder, quotient}
  logic        r_neg_q;  // product / quotient must be negated
  logic        r_neg_r;  // remainder must be negated (dividend negative)
  logic        r_div0;

  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_part;
  logic [32:0] w_div_diff;
  logic [63:0] w_div_next;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign busy = (r_state != S_IDLE);

  // Operand sign / magnitude extraction (op[0]=1 selects unsigned forms)
  assign w_rs_neg = ~op[0] & rs_in[31];
  assign w_rt_neg = ~op[0] & rt_in[31];
  assign w_rs_mag = w_rs_neg ? (~rs_in + 32'd1) : rs_in;
  assign w_rt_mag = w_rt_neg ? (~rt_in + 32'd1) : rt_in;

  // Shift-add step: add multiplicand into upper half when multiplier LSB set,
  // then shift the whole 65-bit {carry, acc} right by one.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // Restoring divide step: shift left, trial-subtract divisor, keep if no borrow.
  assign w_div_part = r_acc[63:31];
  assign w_div_diff = w_div_part - {1'b0, r_opnd};
  assign w_div_next = w_div_diff[32] ? {r_acc[62:0], 1'b0}
                                     : {w_div_diff[31:0], r_acc[30:0], 1'b1};

  // Sign correction applied only at commit
  assign w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
  assign w_quot = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  // Control FSM, datapath iteration and HI/LO commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_op        <= 2'd0;
      r_opnd      <= 32'd0;
      r_acc       <= 64'd0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div0      <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_cnt   <= 5'd0;
            r_neg_q <= w_rs_neg ^ w_rt_neg;
            r_neg_r <= w_rs_neg;
            r_div0  <= op[1] & (rt_in == 32'd0);
            r_opnd  <= op[1] ? w_rt_mag : w_rs_mag;
            r_acc   <= {32'd0, (op[1] ? w_rs_mag : w_rt_mag)};
            r_state <= S_CALC;
          end else begin
            if (hi_we) hi <= rs_in;
            if (lo_we) lo <= rs_in;
          end
        end
        S_CALC: begin
          r_acc <= r_op[1] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIN;
        end
        S_FIN: begin
          if (r_op[1]) begin
            if (!r_div0) begin
              hi <= w_rem;
              lo <= w_quot;
            end
          end else begin
            hi <= w_prod[63:32];
            lo <= w_prod[31:0];
          end
          done        <= 1'b1;
          div_by_zero <= r_div0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed self-checking bench for muldiv_unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_in;
  logic [31:0] rt_in;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  localparam logic [1:0] c_mult  = 2'b00;
  localparam logic [1:0] c_multu = 2'b01;
  localparam logic [1:0] c_div   = 2'b10;
  localparam logic [1:0] c_divu  = 2'b11;

  muldiv_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .rs_in       (rs_in),
    .rt_in       (rt_in),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // MTHI / MTLO write in IDLE
  task automatic mt(input logic wh, input logic wl, input logic [31:0] val);
    @(negedge clk);
    hi_we = wh; lo_we = wl; rs_in = val;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (wh) m_hi = val;
    if (wl) m_lo = val;
  endtask

  // Issue one operation and check latency, hold behaviour and result
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic mtw, input logic [31:0] e_hi,
                        input logic [31:0] e_lo, input logic e_dz);
    int lat;
    lat = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs_in = a; rt_in = b; hi_we = mtw; lo_we = mtw;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    chk({tag, "_busy_hi"}, {63'd0, busy}, 64'd1);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 16) begin
        chk({tag, "_hold_hi"}, {32'd0, hi}, {32'd0, m_hi});
        chk({tag, "_hold_lo"}, {32'd0, lo}, {32'd0, m_lo});
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, 64'(lat), 64'd33);
    chk({tag, "_hi"}, {32'd0, hi}, {32'd0, e_hi});
    chk({tag, "_lo"}, {32'd0, lo}, {32'd0, e_lo});
    chk({tag, "_dz"}, {63'd0, div_by_zero}, {63'd0, e_dz});
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {62'd0, done, div_by_zero}, 64'd0);
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_in = 32'd0; rt_in = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    mt(1'b1, 1'b0, 32'h1234_5678);
    chk("mthi", {32'd0, hi}, 64'h1234_5678);
    mt(1'b0, 1'b1, 32'h0BAD_F00D);
    chk("mtlo", {32'd0, lo}, 64'h0BAD_F00D);
    chk("mtlo_hi_kept", {32'd0, hi}, 64'h1234_5678);

    // start + MTHI/MTLO together: write dropped (visible via hold check)
    run_op("mult_m3x5", c_mult, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("multu_max", c_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_mixed", c_mult, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'hC000_0000, 32'h8000_0000, 1'b0);
    run_op("div_m7d2", c_div, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_7d2", c_divu, 32'd7, 32'd2, 1'b0, 32'd1, 32'd3, 1'b0);
    run_op("div_ovf", c_div, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0);
    run_op("div_100dm7", c_div, 32'd100, 32'hFFFF_FFF9, 1'b0, 32'd2, 32'hFFFF_FFF2, 1'b0);
    mt(1'b1, 1'b0, 32'h1234_5678);
    run_op("divu_by0", c_divu, 32'd7, 32'd0, 1'b0, 32'h1234_5678, 32'hFFFF_FFF2, 1'b1);

    // Reset 10 cycles into a MULT: abort, no commit, no done
    @(negedge clk);
    start = 1'b1; op = c_mult; rs_in = 32'd3; rt_in = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    run_op("mult_4x4", c_mult, 32'd4, 32'd4, 1'b0, 32'd0, 32'd16, 1'b0);

    // Second start + MTLO while busy must be ignored
    mt(1'b1, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    start = 1'b1; op = c_multu; rs_in = 32'd2; rt_in = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = c_divu; rs_in = 32'd9; rt_in = 32'd3; lo_we = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    chk("busy_lo_hold", {32'd0, lo}, 64'hDEAD_BEEF);
    ndone = 0;
    for (int c = 6; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone = c;
        break;
      end
    end
    chk("busy_ign_latency", 64'(ndone), 64'd33);
    chk("busy_ign_lo", {32'd0, lo}, 64'd6);
    chk("busy_ign_hi", {32'd0, hi}, 64'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("busy_ign_no_second", 64'(ndone), 64'd0);
    chk("busy_ign_lo_final", {32'd0, lo}, 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
